issue_select_ctrl: RTL

Issue-queue scheduler for one functional-unit port. It holds up to DEPTH dispatched micro-ops and tracks source-operand readiness from a wakeup broadcast. Each cycle it picks the oldest fully-ready entry, by ROB index relative to the ROB head, and presents it through a registered valid/ready issue port. It sits between rename/dispatch and the FU, and uses the two-way oldest-ready select primitive as the node of its select tree.

---
 rtl/issue_select_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/issue_select_ctrl.sv
// rtl/issue_select_ctrl.sv - issue-queue scheduler with oldest-ready select and registered issue port
//
// Holds up to DEPTH dispatched micro-ops, tracks source readiness from a
// wakeup broadcast, and each cycle moves the oldest fully-ready entry (age =
// rob - rob_head, modulo 2^ROB_W) into a valid/ready issue register.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   flush                    empties the queue and the issue register
//   rob_head                 ROB head index, age reference
//   disp_valid/disp_ready    dispatch handshake
//   disp_rob, disp_src1/2, disp_src1/2_rdy, disp_dst  dispatched op fields
//   wk_valid, wk_tag         wakeup broadcast
//   iss_valid/iss_ready      issue handshake
//   iss_rob, iss_dst         issued op fields
//   occupancy                number of valid queue entries
//
// Build option: ISSUE_WAKEUP_BYPASS_EN lets a same-cycle wakeup make an entry
// a select candidate (one cycle less wakeup-to-issue latency).

module issue_select_ctrl #(
  parameter int DEPTH  = 8,
  parameter int ROB_W  = 5,
  parameter int PREG_W = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [ROB_W-1:0]           rob_head,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [ROB_W-1:0]           disp_rob,
  input  logic [PREG_W-1:0]          disp_src1,
  input  logic [PREG_W-1:0]          disp_src2,
  input  logic                       disp_src1_rdy,
  input  logic                       disp_src2_rdy,
  input  logic [PREG_W-1:0]          disp_dst,
  input  logic                       wk_valid,
  input  logic [PREG_W-1:0]          wk_tag,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [ROB_W-1:0]           iss_rob,
  output logic [PREG_W-1:0]          iss_dst,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam int NODES = 2 * DEPTH - 1;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  r1_q, r1_d;
  logic [DEPTH-1:0]  r2_q, r2_d;
  logic [ROB_W-1:0]  rob_q  [DEPTH];
  logic [PREG_W-1:0] src1_q [DEPTH];
  logic [PREG_W-1:0] src2_q [DEPTH];
  logic [PREG_W-1:0] dst_q  [DEPTH];

  logic              iss_valid_q, iss_valid_d;
  logic [ROB_W-1:0]  iss_rob_q, iss_rob_d;
  logic [PREG_W-1:0] iss_dst_q, iss_dst_d;
  logic [CNT_W-1:0]  occ_q, occ_d;

  logic [DEPTH-1:0]  wk1, wk2, cand;
  logic              free_found;
  logic [IDX_W-1:0]  free_idx;
  logic              disp_fire, iss_load, sel;
  logic              disp_wk1, disp_wk2;

  // Select tree stored as a heap: node n has children 2n+1 and 2n+2,
  // leaves sit at DEPTH-1+i, the root (node 0) is the overall winner.
  logic              node_v [NODES];
  logic [IDX_W-1:0]  node_i [NODES];
  logic [ROB_W-1:0]  node_a [NODES];

  // Two-way oldest-ready node: take the second input when it is ready and
  // either the first is not ready or the second has the smaller age key.
  function automatic logic pick_second(input logic v0, input logic [ROB_W-1:0] a0,
                                       input logic v1, input logic [ROB_W-1:0] a1);
    return v1 && (!v0 || (a1 < a0));
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wk1[i] = valid_q[i] && wk_valid && (src1_q[i] == wk_tag);
      wk2[i] = valid_q[i] && wk_valid && (src2_q[i] == wk_tag);
`ifdef ISSUE_WAKEUP_BYPASS_EN
      cand[i] = valid_q[i] && (r1_q[i] || wk1[i]) && (r2_q[i] || wk2[i]);
`else
      cand[i] = valid_q[i] && r1_q[i] && r2_q[i];
`endif
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      node_v[DEPTH-1+i] = cand[i];
      node_i[DEPTH-1+i] = IDX_W'(i);
      node_a[DEPTH-1+i] = rob_q[i] - rob_head;  // wraps modulo 2^ROB_W
    end
    for (int n = DEPTH - 2; n >= 0; n--) begin
      node_v[n] = node_v[2*n+1] || node_v[2*n+2];
      if (pick_second(node_v[2*n+1], node_a[2*n+1], node_v[2*n+2], node_a[2*n+2])) begin
        node_i[n] = node_i[2*n+2];
        node_a[n] = node_a[2*n+2];
      end else begin
        node_i[n] = node_i[2*n+1];
        node_a[n] = node_a[2*n+1];
      end
    end
  end

  // Lowest-index free slot, judged from the start-of-cycle valid set so a
  // slot vacated by this cycle's issue is not reused until the next cycle.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign disp_ready = free_found && !flush;
  assign disp_fire  = disp_valid && disp_ready;
  assign iss_load   = !iss_valid_q || iss_ready;
  assign sel        = !flush && iss_load && node_v[0];
  assign disp_wk1   = wk_valid && (disp_src1 == wk_tag);
  assign disp_wk2   = wk_valid && (disp_src2 == wk_tag);

  always_comb begin
    valid_d     = valid_q;
    r1_d        = r1_q | wk1;
    r2_d        = r2_q | wk2;
    iss_valid_d = iss_valid_q;
    iss_rob_d   = iss_rob_q;
    iss_dst_d   = iss_dst_q;
    occ_d       = occ_q + CNT_W'(disp_fire) - CNT_W'(sel);
    if (flush) begin
      valid_d     = '0;
      iss_valid_d = 1'b0;
      occ_d       = '0;
    end else begin
      if (iss_load) begin
        iss_valid_d = node_v[0];
        if (node_v[0]) begin
          iss_rob_d         = rob_q[node_i[0]];
          iss_dst_d         = dst_q[node_i[0]];
          valid_d[node_i[0]] = 1'b0;
        end
      end
      if (disp_fire) begin
        valid_d[free_idx] = 1'b1;
        r1_d[free_idx]    = disp_src1_rdy || disp_wk1;
        r2_d[free_idx]    = disp_src2_rdy || disp_wk2;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= '0;
      r1_q        <= '0;
      r2_q        <= '0;
      iss_valid_q <= 1'b0;
      iss_rob_q   <= '0;
      iss_dst_q   <= '0;
      occ_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      r1_q        <= r1_d;
      r2_q        <= r2_d;
      iss_valid_q <= iss_valid_d;
      iss_rob_q   <= iss_rob_d;
      iss_dst_q   <= iss_dst_d;
      occ_q       <= occ_d;
    end
  end

  // Payload fields are qualified by valid_q, so they need no reset.
  always_ff @(posedge clk) begin
    if (disp_fire) begin
      rob_q[free_idx]  <= disp_rob;
      src1_q[free_idx] <= disp_src1;
      src2_q[free_idx] <= disp_src2;
      dst_q[free_idx]  <= disp_dst;
    end
  end

  assign iss_valid = iss_valid_q;
  assign iss_rob   = iss_rob_q;
  assign iss_dst   = iss_dst_q;
  assign occupancy = occ_q;

endmodule
